// File: rtl/ederah_arb_pkg.sv
// Shared types and constants for the ederah stream arbiter.
package ederah_arb_pkg;

  localparam logic STYPE_NFA   = 1'b0;
  localparam logic STYPE_QUERY = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_e;

  // Bits needed to index n requester ports (at least one).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ederah_tag_fifo.sv
// In-order FIFO of requester tags for outstanding queries; head is the owner of the next result.
module ederah_tag_fifo #(
  parameter int unsigned G_TAG_W = 2,
  parameter int unsigned G_DEPTH = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        push_i,
  input  logic [G_TAG_W-1:0]          tag_i,
  input  logic                        pop_i,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [G_TAG_W-1:0]          head_o,
  output logic [$clog2(G_DEPTH):0]    level_o
);

  localparam int unsigned AW = $clog2(G_DEPTH);

  logic [G_TAG_W-1:0] mem [G_DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;

  // Extra pointer MSB distinguishes full from empty when the indices coincide.
  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_o  = mem[rd_ptr[AW-1:0]];
  assign level_o = wr_ptr - rd_ptr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_i)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr[AW-1:0]] <= tag_i;
  end

endmodule

// File: rtl/ederah_stream_arbiter.sv
// Packet-granular round-robin sharing of one ederah engine; results are routed back via the tag FIFO.
module ederah_stream_arbiter
  import ederah_arb_pkg::*;
#(
  parameter  int unsigned G_NUM_PORTS      = 4,
  parameter  int unsigned G_DATA_BUS_WIDTH = 512,
  parameter  int unsigned G_TAG_DEPTH      = 16,
  localparam int unsigned PW               = idx_width(G_NUM_PORTS)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [G_NUM_PORTS*G_DATA_BUS_WIDTH-1:0] req_data_i,
  input  logic [G_NUM_PORTS-1:0]                 req_valid_i,
  input  logic [G_NUM_PORTS-1:0]                 req_last_i,
  input  logic [G_NUM_PORTS-1:0]                 req_stype_i,
  output logic [G_NUM_PORTS-1:0]                 req_ready_o,
  output logic [G_DATA_BUS_WIDTH-1:0]            eng_data_o,
  output logic                                   eng_valid_o,
  output logic                                   eng_last_o,
  output logic                                   eng_stype_o,
  input  logic                                   eng_ready_i,
  input  logic [G_DATA_BUS_WIDTH-1:0]            res_data_i,
  input  logic                                   res_valid_i,
  input  logic                                   res_last_i,
  output logic                                   res_ready_o,
  output logic [G_DATA_BUS_WIDTH-1:0]            rsp_data_o,
  output logic [G_NUM_PORTS-1:0]                 rsp_valid_o,
  output logic [G_NUM_PORTS-1:0]                 rsp_last_o,
  input  logic [G_NUM_PORTS-1:0]                 rsp_ready_i,
  output logic [PW-1:0]                          grant_o,
  output logic                                   busy_o,
  output logic                                   err_o
);

  localparam int unsigned AW = $clog2(G_TAG_DEPTH);

  arb_state_e              state_q, state_d;
  logic [PW-1:0]           grant_q, grant_d;
  logic [PW-1:0]           rr_q, rr_d;
  logic [PW-1:0]           winner, cand;
  logic                    found;
  logic [G_NUM_PORTS-1:0]  eligible;
  logic                    pkt_stype_q;
  logic                    err_set, busy_d;

  logic                    tag_push, tag_pop, tag_full, tag_empty;
  logic [PW-1:0]           tag_head;
  logic [AW:0]             tag_level, tag_level_nxt;

  ederah_tag_fifo #(
    .G_TAG_W (PW),
    .G_DEPTH (G_TAG_DEPTH)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (tag_push),
    .tag_i   (winner),
    .pop_i   (tag_pop),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .head_o  (tag_head),
    .level_o (tag_level)
  );

  // Result routing to the owner at the FIFO head; independent of the input FSM.
  always_comb begin
    rsp_valid_o = '0;
    rsp_last_o  = '0;
    res_ready_o = 1'b0;
    if (!tag_empty) begin
      rsp_valid_o[tag_head] = res_valid_i;
      rsp_last_o[tag_head]  = res_last_i;
      res_ready_o           = rsp_ready_i[tag_head];
    end
  end

  assign rsp_data_o = res_data_i;
  assign tag_pop    = res_valid_i & res_ready_o & res_last_i;

  // A pop in the same cycle frees a slot, so a query may still win against a full FIFO.
  always_comb begin
    for (int unsigned p = 0; p < G_NUM_PORTS; p++) begin
      eligible[p] = req_valid_i[p] & ((req_stype_i[p] == STYPE_NFA) | ~tag_full | tag_pop);
    end
  end

  always_comb begin
    winner = rr_q;
    found  = 1'b0;
    cand   = rr_q;
    for (int unsigned k = 1; k <= G_NUM_PORTS; k++) begin
      cand = PW'((32'(rr_q) + k) % G_NUM_PORTS);
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    tag_push    = 1'b0;
    eng_data_o  = '0;
    eng_valid_o = 1'b0;
    eng_last_o  = 1'b0;
    eng_stype_o = 1'b0;
    req_ready_o = '0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d  = ST_XFER;
          grant_d  = winner;
          rr_d     = winner;
          tag_push = (req_stype_i[winner] == STYPE_QUERY);
        end
      end
      ST_XFER: begin
        eng_data_o           = req_data_i[32'(grant_q)*G_DATA_BUS_WIDTH +: G_DATA_BUS_WIDTH];
        eng_valid_o          = req_valid_i[grant_q];
        eng_last_o           = req_last_i[grant_q];
        eng_stype_o          = req_stype_i[grant_q];
        req_ready_o[grant_q] = eng_ready_i;
        if (eng_valid_o && eng_ready_i && eng_last_o) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tag_level_nxt = tag_level + (AW+1)'(tag_push) - (AW+1)'(tag_pop);
  assign busy_d        = (state_d != ST_IDLE) | (tag_level_nxt != '0);
  assign err_set       = ((state_q == ST_XFER) & req_valid_i[grant_q] &
                          (req_stype_i[grant_q] != pkt_stype_q)) |
                         (tag_empty & res_valid_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_q        <= PW'(G_NUM_PORTS - 1);
      pkt_stype_q <= STYPE_NFA;
      busy_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      busy_o  <= busy_d;
      if ((state_q == ST_IDLE) && found) pkt_stype_q <= req_stype_i[winner];
      if (err_set) err_o <= 1'b1;
    end
  end

  assign grant_o = grant_q;

endmodule

// File: tb/tb_ederah_stream_arbiter.sv
// Scoreboard bench: per-port packet queues, engine/result model, decoupled output monitor.
module tb_ederah_stream_arbiter;
  import ederah_arb_pkg::*;

  localparam int unsigned NP = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned TD = 2;
  localparam int unsigned PW = 2;
  localparam int unsigned RW = DW - 3;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          stype;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NP*DW-1:0] req_data;
  logic [NP-1:0]    req_valid, req_last, req_stype, req_ready;
  logic [DW-1:0]    eng_data;
  logic             eng_valid, eng_last, eng_stype, eng_ready;
  logic [DW-1:0]    res_data;
  logic             res_valid, res_last, res_ready;
  logic [DW-1:0]    rsp_data;
  logic [NP-1:0]    rsp_valid, rsp_last, rsp_ready;
  logic [PW-1:0]    grant;
  logic             busy, err;

  always #5 clk = ~clk;

  ederah_stream_arbiter #(
    .G_NUM_PORTS      (NP),
    .G_DATA_BUS_WIDTH (DW),
    .G_TAG_DEPTH      (TD)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_data_i  (req_data),
    .req_valid_i (req_valid),
    .req_last_i  (req_last),
    .req_stype_i (req_stype),
    .req_ready_o (req_ready),
    .eng_data_o  (eng_data),
    .eng_valid_o (eng_valid),
    .eng_last_o  (eng_last),
    .eng_stype_o (eng_stype),
    .eng_ready_i (eng_ready),
    .res_data_i  (res_data),
    .res_valid_i (res_valid),
    .res_last_i  (res_last),
    .res_ready_o (res_ready),
    .rsp_data_o  (rsp_data),
    .rsp_valid_o (rsp_valid),
    .rsp_last_o  (rsp_last),
    .rsp_ready_i (rsp_ready),
    .grant_o     (grant),
    .busy_o      (busy),
    .err_o       (err)
  );

  beat_t src_q   [NP][$];
  beat_t eng_exp [NP][$];
  beat_t rsp_exp [NP][$];
  beat_t res_q   [$];
  int    gq      [$];

  int          checks = 0;
  int          errors = 0;
  logic        rnd = 1'b0;
  int          eng_mode = 1;
  logic        res_hold = 1'b0;
  logic [NP-1:0] rsp_mask = '1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic send_pkt(input int p, input logic st, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data  = {3'(p), RW'($urandom)};
      b.last  = (i == len - 1);
      b.stype = st;
      src_q[p].push_back(b);
      eng_exp[p].push_back(b);
    end
  endtask

  function automatic bit all_empty();
    bit e = (res_q.size() == 0);
    for (int p = 0; p < NP; p++)
      if (src_q[p].size() || eng_exp[p].size() || rsp_exp[p].size()) e = 0;
    return e;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    bit done = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
      done = all_empty() && !busy;
    end
    check(name, 64'(done), 64'(1));
  endtask

  task automatic wait_left(input string name, input int p, input int k, input int budget);
    int n = 0;
    while (eng_exp[p].size() != k && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(eng_exp[p].size()), 64'(k));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic flush();
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      eng_exp[p].delete();
      rsp_exp[p].delete();
    end
    res_q.delete();
    gq.delete();
  endtask

  task automatic check_reset_outs(input string name);
    check(name, 64'({eng_valid, req_ready, res_ready, rsp_valid, grant, busy, err}), 64'(0));
  endtask

  // Requester drivers plus engine model: a completed query produces a random-length result.
  initial begin : drv
    logic [NP-1:0] fire_r;
    logic          e_fire, e_last, e_stype, r_fire;
    int            owner, len;
    beat_t         b;
    req_valid = '0; req_data = '0; req_last = '0; req_stype = '0;
    eng_ready = 1'b0; res_valid = 1'b0; res_data = '0; res_last = 1'b0; rsp_ready = '0;
    forever begin
      @(negedge clk);
      fire_r  = req_valid & req_ready;
      e_fire  = eng_valid & eng_ready;
      e_last  = eng_last;
      e_stype = eng_stype;
      r_fire  = res_valid & res_ready;
      @(posedge clk);
      #1;
      if (rst) begin
        req_valid = '0; eng_ready = 1'b0; res_valid = 1'b0; rsp_ready = '0;
      end else begin
        for (int p = 0; p < NP; p++)
          if (fire_r[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
        if (e_fire && e_last && e_stype == STYPE_QUERY) begin
          owner = -1;
          for (int p = 0; p < NP; p++) if (fire_r[p]) owner = p;
          if (owner >= 0) begin
            len = $urandom_range(1, 3);
            for (int i = 0; i < len; i++) begin
              b.data = DW'($urandom); b.last = (i == len - 1); b.stype = 1'b0;
              res_q.push_back(b);
              rsp_exp[owner].push_back(b);
            end
          end
        end
        if (r_fire && res_q.size() > 0) void'(res_q.pop_front());
        for (int p = 0; p < NP; p++) begin
          req_valid[p] = (src_q[p].size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
          if (src_q[p].size() > 0) begin
            req_data[p*DW +: DW] = src_q[p][0].data;
            req_last[p]          = src_q[p][0].last;
            req_stype[p]         = src_q[p][0].stype;
          end
        end
        eng_ready = (eng_mode == 1) || (eng_mode == 2 && $urandom_range(0, 3) != 0);
        res_valid = (res_q.size() > 0) && !res_hold && (!rnd || $urandom_range(0, 2) != 0);
        if (res_q.size() > 0) begin
          res_data = res_q[0].data;
          res_last = res_q[0].last;
        end
        rsp_ready = rsp_mask & (rnd ? NP'($urandom) : '1);
      end
    end
  end

  logic  in_pkt = 1'b0;
  logic  bubble = 1'b0;
  int    mon_p;
  beat_t mon_e;

  // Monitor: pops expected beats whenever the DUT hands something over.
  always @(negedge clk) begin : mon
    if (rst) begin
      in_pkt = 1'b0;
      bubble = 1'b0;
    end else begin
      if (bubble) begin
        check("bubble", 64'({eng_valid, |req_ready}), 64'(0));
        bubble = 1'b0;
      end
      if (|req_ready) check("ready_onehot", 64'($countones(req_ready)), 64'(1));
      if (eng_valid && eng_ready) begin
        mon_p = int'(eng_data[DW-1 -: 3]);
        check("eng_port", 64'(mon_p < NP && eng_exp[mon_p].size() > 0), 64'(1));
        if (mon_p < NP && eng_exp[mon_p].size() > 0) begin
          mon_e = eng_exp[mon_p].pop_front();
          check("eng_beat", 64'({eng_data, eng_last, eng_stype}), 64'(mon_e));
          check("eng_grant", 64'(grant), 64'(mon_p));
          if (!in_pkt && gq.size() > 0) check("rr_order", 64'(mon_p), 64'(gq.pop_front()));
        end
        in_pkt = !eng_last;
        bubble = eng_last;
      end
      if (|rsp_valid) check("rsp_onehot", 64'($countones(rsp_valid)), 64'(1));
      for (int p = 0; p < NP; p++) begin
        if (rsp_valid[p] && rsp_ready[p]) begin
          check("rsp_port", 64'(rsp_exp[p].size() > 0), 64'(1));
          if (rsp_exp[p].size() > 0) begin
            mon_e = rsp_exp[p].pop_front();
            check("rsp_beat", 64'({rsp_data, rsp_last[p]}), 64'({mon_e.data, mon_e.last}));
          end
        end
      end
    end
  end

  initial begin : main
    #3;
    check_reset_outs("reset_outs");
    cycles(3);
    rst = 1'b0;

    // Single 3-beat query from port 0: one IDLE cycle before the first beat.
    @(negedge clk);
    send_pkt(0, STYPE_QUERY, 3);
    gq.push_back(0);
    @(negedge clk);
    check("arb_cycle", 64'({eng_valid, req_valid[0]}), 64'(2'b01));
    @(negedge clk);
    check("first_beat", 64'({eng_valid, grant}), 64'({1'b1, 2'd0}));
    wait_drain("drain_single", 200);
    check("busy_after", 64'(busy), 64'(0));

    // Ports 0,1,3 contend; last grant was 0, so rotation starts at 1.
    send_pkt(0, STYPE_QUERY, 2); send_pkt(1, STYPE_QUERY, 2); send_pkt(3, STYPE_QUERY, 2);
    send_pkt(0, STYPE_QUERY, 2); send_pkt(1, STYPE_QUERY, 2); send_pkt(3, STYPE_QUERY, 2);
    gq = '{1, 3, 0, 1, 3, 0};
    wait_drain("drain_rr", 500);

    // NFA load then query on port 2; only the query is answered.
    send_pkt(2, STYPE_NFA, 4);
    send_pkt(2, STYPE_QUERY, 1);
    gq = '{2, 2};
    wait_drain("drain_nfa", 300);

    // Tag FIFO full: third query waits, NFA from port 0 still granted; then a stalled response.
    res_hold = 1'b1;
    rsp_mask = 4'b1101;
    send_pkt(1, STYPE_QUERY, 2); send_pkt(1, STYPE_QUERY, 2); send_pkt(1, STYPE_QUERY, 2);
    gq = '{1, 1, 0, 1};
    wait_left("two_queries", 1, 2, 100);
    cycles(5);
    check("q3_blocked", 64'({eng_valid, busy}), 64'(2'b01));
    send_pkt(0, STYPE_NFA, 2);
    wait_left("nfa_granted", 0, 0, 100);
    res_hold = 1'b0;
    cycles(4);
    check("rsp_stall", 64'({res_valid, res_ready, rsp_valid[1], eng_valid}), 64'(4'b1010));
    rsp_mask = '1;
    wait_drain("drain_full", 500);

    // Reset while an NFA packet is stuck mid-transfer with two tags outstanding.
    res_hold = 1'b1;
    send_pkt(2, STYPE_QUERY, 1); send_pkt(2, STYPE_QUERY, 1);
    gq = '{2, 2};
    wait_left("two_tags", 2, 0, 100);
    eng_mode = 0;
    send_pkt(3, STYPE_NFA, 3);
    cycles(4);
    check("mid_xfer", 64'({eng_valid, grant, busy}), 64'({1'b1, 2'd3, 1'b1}));
    rst = 1'b1;
    #1;
    check_reset_outs("rst_outs");
    flush();
    cycles(2);
    rst = 1'b0;
    eng_mode = 1;
    res_hold = 1'b0;
    send_pkt(3, STYPE_QUERY, 1); send_pkt(0, STYPE_QUERY, 1);
    gq = '{0, 3};
    wait_drain("drain_after_rst", 200);
    check("no_err_yet", 64'(err), 64'(0));

    // Result with no outstanding tag: error is sticky and the result is not consumed.
    b_inject();
    cycles(3);
    check("err_set", 64'({err, res_valid, res_ready}), 64'(3'b110));
    cycles(4);
    check("err_sticky", 64'(err), 64'(1));
    rst = 1'b1;
    #1;
    check("err_cleared", 64'(err), 64'(0));
    flush();
    cycles(2);
    rst = 1'b0;

    // Randomized traffic with stalls on every interface.
    rnd = 1'b1;
    eng_mode = 2;
    @(negedge clk);
    for (int i = 0; i < 60; i++)
      send_pkt($urandom_range(0, NP - 1), 1'($urandom), $urandom_range(1, 4));
    wait_drain("drain_random", 20000);
    check("rand_err", 64'(err), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic b_inject();
    beat_t b;
    b.data = DW'(16'hABCD); b.last = 1'b1; b.stype = 1'b0;
    res_q.push_back(b);
  endtask

endmodule
